csr_access_unit: RTL and testbench

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 165 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one CSR read-modify-write per request
// (IDLE -> READ -> WRITE -> RESP) against a combinational CSR file.
// Optional build macro: CSR_ILLEGAL_TRAP_EN enables illegal-access checking
// (address window, read-only offsets, no-write funct3 encodings).
module csr_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rs1_idx,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_we,
  input  logic [31:0] csr_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       funct3_q;
  logic [AW-1:0]    addr_q;
  logic [XLEN-1:0]  rs1_val_q;
  logic [REG_W-1:0] rs1_idx_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0]  old_q;
  logic [XLEN-1:0]  resp_rdata_q;
  logic [REG_W-1:0] resp_rd_q;
  logic             resp_illegal_q;

  logic             accept_c;
  logic             wr_en_c;
  logic             illegal_c;
  logic [XLEN-1:0]  src_c;
  logic [XLEN-1:0]  wdata_c;

  assign accept_c = req_valid && req_ready;

  // Next-state logic; flush aborts any access in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_READ;
      S_READ:  state_d = flush ? S_IDLE : S_WRITE;
      S_WRITE: state_d = flush ? S_IDLE : S_RESP;
      S_RESP:  if (flush || resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request capture on the accept cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= '0;
      rd_q      <= '0;
    end else if (accept_c) begin
      funct3_q  <= req_funct3;
      addr_q    <= req_addr;
      rs1_val_q <= req_rs1_val;
      rs1_idx_q <= req_rs1_idx;
      rd_q      <= req_rd;
    end
  end

  // Old CSR value sampled at the end of READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  old_q <= '0;
    else if (state_q == S_READ) old_q <= csr_rdata;
  end

  // Source operand: register value or zero-extended zimm.
  assign src_c = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_val_q;

  // Write-enable qualification and write data by op type.
  always_comb begin
    wr_en_c = 1'b0;
    wdata_c = old_q;
    case (funct3_q[1:0])
      2'b01: begin
        wr_en_c = 1'b1;
        wdata_c = src_c;
      end
      2'b10: begin
        wr_en_c = (rs1_idx_q != 5'd0);
        wdata_c = old_q | src_c;
      end
      2'b11: begin
        wr_en_c = (rs1_idx_q != 5'd0);
        wdata_c = old_q & ~src_c;
      end
      default: begin
        wr_en_c = 1'b0;
        wdata_c = old_q;
      end
    endcase
  end

`ifdef CSR_ILLEGAL_TRAP_EN
  logic addr_ok_c;

  // Legal address windows are four 8-entry blocks.
  always_comb begin
    addr_ok_c = 1'b0;
    case (addr_q[AW-1:3])
      9'h0FC, 9'h0FE, 9'h100, 9'h120: addr_ok_c = 1'b1;
      default:                        addr_ok_c = 1'b0;
    endcase
  end

  // Offsets 5-7 of each block are read-only; funct3 x00 is reserved.
  assign illegal_c = !addr_ok_c
                   || (wr_en_c && (addr_q[2:0] >= 3'd5))
                   || (funct3_q[1:0] == 2'b00);
`else
  assign illegal_c = 1'b0;
`endif

  // Response payload frozen when WRITE completes, held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata_q   <= '0;
      resp_rd_q      <= '0;
      resp_illegal_q <= 1'b0;
    end else if ((state_q == S_WRITE) && !flush) begin
      resp_rdata_q   <= illegal_c ? '0 : old_q;
      resp_rd_q      <= rd_q;
      resp_illegal_q <= illegal_c;
    end
  end

  assign req_ready    = (state_q == S_IDLE) && !flush;
  assign csr_addr     = addr_q;
  assign csr_wdata    = wdata_c;
  assign csr_we       = (state_q == S_WRITE) && wr_en_c && !illegal_c && !flush;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = resp_rdata_q;
  assign resp_rd      = resp_rd_q;
  assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: scoreboard bench for csr_access_unit with a
// behavioural CSR file; expectations are constants pushed per request.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_rs1_val = 32'd0;
  logic [4:0]  req_rs1_idx = 5'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_illegal;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx), .req_rd(req_rd),
    .flush(flush),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_illegal(resp_illegal)
  );

  // Behavioural CSR file: combinational read, write on rising edge.
  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) if (csr_we) csr_mem[csr_addr] = csr_wdata;

  typedef struct {
    int          we_cnt;
    logic [31:0] wdata;
    int          we_cyc;
    int          resp_cyc;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        ill;
    logic        stable;
    logic        rr_low;
    logic        acc_ready;
  } obs_t;

  typedef struct {
    int          we_cnt;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  // Drives one request and records what the DUT does; cycle k = k-th falling edge after accept.
  task automatic run_access(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] v,
                            input logic [4:0] idx, input logic [4:0] rd, input int hold,
                            output obs_t o);
    int held;
    o.we_cnt = 0; o.wdata = '0; o.we_cyc = 0; o.resp_cyc = 0; o.rdata = '0;
    o.rd = '0; o.ill = 1'b0; o.stable = 1'b1; o.rr_low = 1'b1; o.acc_ready = 1'b0;
    held = 0;
    @(negedge clk);
    o.acc_ready = req_ready;
    req_valid = 1'b1; req_funct3 = f3; req_addr = a;
    req_rs1_val = v; req_rs1_idx = idx; req_rd = rd; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (csr_we) begin o.we_cnt++; o.wdata = csr_wdata; o.we_cyc = k; end
      if (resp_valid) begin
        if (o.resp_cyc == 0) begin
          o.resp_cyc = k; o.rdata = resp_rdata; o.rd = resp_rd; o.ill = resp_illegal;
        end else if (resp_rdata !== o.rdata || resp_rd !== o.rd || resp_illegal !== o.ill) begin
          o.stable = 1'b0;
        end
        if (req_ready !== 1'b0) o.rr_low = 1'b0;
        if (held >= hold) begin
          resp_ready = 1'b1;
          @(posedge clk);
          #1 resp_ready = 1'b0;
          break;
        end
        held++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({csr_addr, csr_wdata, csr_we} !== 45'd0) begin n_fail++;
      $display("FAIL reset_csr_side: got %h expected 0", {csr_addr, csr_wdata, csr_we}); end
    n_chk++; if ({resp_valid, resp_rdata, resp_rd, resp_illegal} !== 39'd0) begin n_fail++;
      $display("FAIL reset_resp_side: got %h expected 0", {resp_valid, resp_rdata, resp_rd, resp_illegal}); end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_rw();
    obs_t o; exp_t e;
    csr_mem[12'h7E0] = 32'h0;
    sb_q.push_back('{1, 32'h12345678, 32'h0, 5'd3, 1'b0});
    run_access(3'b001, 12'h7E0, 32'h12345678, 5'd1, 5'd3, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || o.we_cyc != 2) begin n_fail++;
      $display("FAIL rw_we: got cnt %0d cyc %0d expected cnt %0d cyc 2", o.we_cnt, o.we_cyc, e.we_cnt); end
    n_chk++; if (o.wdata !== e.wdata) begin n_fail++;
      $display("FAIL rw_wdata: got %h expected %h", o.wdata, e.wdata); end
    n_chk++; if (o.resp_cyc != 3) begin n_fail++;
      $display("FAIL rw_latency: got %0d expected 3", o.resp_cyc); end
    n_chk++; if ({o.rdata, o.rd, o.ill} !== {e.rdata, e.rd, e.ill}) begin n_fail++;
      $display("FAIL rw_resp: got %h/%0d/%b expected %h/%0d/%b", o.rdata, o.rd, o.ill, e.rdata, e.rd, e.ill); end
    n_chk++; if (csr_mem[12'h7E0] !== 32'h12345678) begin n_fail++;
      $display("FAIL rw_csr_content: got %h expected 12345678", csr_mem[12'h7E0]); end
  endtask

  task automatic test_rs();
    obs_t o; exp_t e;
    csr_mem[12'h801] = 32'h0F0F0000;
    sb_q.push_back('{1, 32'h0F0F00FF, 32'h0F0F0000, 5'd7, 1'b0});
    run_access(3'b010, 12'h801, 32'h000000FF, 5'd5, 5'd7, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || o.wdata !== e.wdata) begin n_fail++;
      $display("FAIL rs_write: got %0d/%h expected %0d/%h", o.we_cnt, o.wdata, e.we_cnt, e.wdata); end
    n_chk++; if ({o.rdata, o.rd, o.ill} !== {e.rdata, e.rd, e.ill}) begin n_fail++;
      $display("FAIL rs_resp: got %h/%0d/%b expected %h/%0d/%b", o.rdata, o.rd, o.ill, e.rdata, e.rd, e.ill); end
  endtask

  task automatic test_imm();
    obs_t o; exp_t e;
    csr_mem[12'h7F2] = 32'hFFFFFFFF;
    sb_q.push_back('{1, 32'hFFFFFFFC, 32'hFFFFFFFF, 5'd4, 1'b0});
    run_access(3'b111, 12'h7F2, 32'hA5A5A5A5, 5'd3, 5'd4, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || o.wdata !== e.wdata) begin n_fail++;
      $display("FAIL rci_write: got %0d/%h expected %0d/%h", o.we_cnt, o.wdata, e.we_cnt, e.wdata); end
    n_chk++; if (o.rdata !== e.rdata) begin n_fail++;
      $display("FAIL rci_rdata: got %h expected %h", o.rdata, e.rdata); end
    sb_q.push_back('{0, 32'h0, 32'hFFFFFFFC, 5'd6, 1'b0});
    run_access(3'b110, 12'h7F2, 32'hFFFFFFFF, 5'd0, 5'd6, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt) begin n_fail++;
      $display("FAIL rsi_zero_we: got %0d expected %0d", o.we_cnt, e.we_cnt); end
    n_chk++; if ({o.rdata, o.rd, o.resp_cyc} !== {e.rdata, e.rd, 3}) begin n_fail++;
      $display("FAIL rsi_zero_resp: got %h/%0d/%0d expected %h/%0d/3", o.rdata, o.rd, o.resp_cyc, e.rdata, e.rd); end
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    csr_mem[12'h7E5] = 32'h00000077;
    csr_mem[12'h807] = 32'h31415926;
    csr_mem[12'h7E8] = 32'h00000042;
`ifdef CSR_ILLEGAL_TRAP_EN
    sb_q.push_back('{0, 32'h0, 32'h0, 5'd2, 1'b1});
    sb_q.push_back('{0, 32'h0, 32'h0, 5'd8, 1'b1});
    sb_q.push_back('{0, 32'h0, 32'h0, 5'd11, 1'b1});
`else
    sb_q.push_back('{1, 32'h00000099, 32'h00000077, 5'd2, 1'b0});
    sb_q.push_back('{0, 32'h0, 32'h31415926, 5'd8, 1'b0});
    sb_q.push_back('{1, 32'h00000055, 32'h00000042, 5'd11, 1'b0});
`endif
    run_access(3'b001, 12'h7E5, 32'h00000099, 5'd1, 5'd2, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || (e.we_cnt == 1 && o.wdata !== e.wdata)) begin n_fail++;
      $display("FAIL ro_offset_write: got %0d/%h expected %0d/%h", o.we_cnt, o.wdata, e.we_cnt, e.wdata); end
    n_chk++; if ({o.rdata, o.rd, o.ill} !== {e.rdata, e.rd, e.ill}) begin n_fail++;
      $display("FAIL ro_offset_resp: got %h/%0d/%b expected %h/%0d/%b", o.rdata, o.rd, o.ill, e.rdata, e.rd, e.ill); end
    run_access(3'b000, 12'h807, 32'hFFFFFFFF, 5'd9, 5'd8, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || {o.rdata, o.rd, o.ill} !== {e.rdata, e.rd, e.ill}) begin n_fail++;
      $display("FAIL funct3_000: got %0d/%h/%0d/%b expected %0d/%h/%0d/%b",
               o.we_cnt, o.rdata, o.rd, o.ill, e.we_cnt, e.rdata, e.rd, e.ill); end
    run_access(3'b001, 12'h7E8, 32'h00000055, 5'd1, 5'd11, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.we_cnt != e.we_cnt || {o.rdata, o.rd, o.ill} !== {e.rdata, e.rd, e.ill}) begin n_fail++;
      $display("FAIL out_of_window: got %0d/%h/%0d/%b expected %0d/%h/%0d/%b",
               o.we_cnt, o.rdata, o.rd, o.ill, e.we_cnt, e.rdata, e.rd, e.ill); end
  endtask

  task automatic test_flush();
    int seen;
    csr_mem[12'h7E1] = 32'hAAAA5555;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h7E1;
    req_rs1_val = 32'h11111111; req_rs1_idx = 5'd1; req_rd = 5'd12;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (csr_we !== 1'b1) begin n_fail++;
      $display("FAIL flush_pre_we: got %b expected 1", csr_we); end
    flush = 1'b1;
    #1;
    n_chk++; if (csr_we !== 1'b0) begin n_fail++;
      $display("FAIL flush_write_we: got %b expected 0", csr_we); end
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || csr_we) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++;
      $display("FAIL flush_no_resp: got %0d active cycles expected 0", seen); end
    n_chk++; if (csr_mem[12'h7E1] !== 32'hAAAA5555) begin n_fail++;
      $display("FAIL flush_csr_content: got %h expected aaaa5555", csr_mem[12'h7E1]); end
    // Flush while idle must block acceptance.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_addr = 12'h7E2;
    #1;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_idle_ready: got %b expected 0", req_ready); end
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_idle_not_accepted: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    csr_mem[12'h7E3] = 32'h00005A5A;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h7E3;
    req_rs1_val = 32'hDEADBEEF; req_rs1_idx = 5'd1; req_rd = 5'd13;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b0 || csr_addr !== 12'h7E3) begin n_fail++;
      $display("FAIL read_state: got ready %b addr %h expected 0/7e3", req_ready, csr_addr); end
    reset = 1'b1;
    #1;
    n_chk++; if ({csr_addr, csr_wdata, csr_we, resp_valid, resp_rdata, resp_rd, resp_illegal} !== 84'd0) begin n_fail++;
      $display("FAIL reset_mid_outputs: got %h expected 0",
               {csr_addr, csr_wdata, csr_we, resp_valid, resp_rdata, resp_rd, resp_illegal}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_mid_idle: got %b expected 1", req_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (csr_mem[12'h7E3] !== 32'h00005A5A || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid_no_write: got %h/%b expected 00005a5a/0", csr_mem[12'h7E3], resp_valid); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    csr_mem[12'h900] = 32'hCAFEF00D;
    sb_q.push_back('{1, 32'hCAFEF01D, 32'hCAFEF00D, 5'd9, 1'b0});
    sb_q.push_back('{1, 32'h00000000, 32'hCAFEF01D, 5'd10, 1'b0});
    run_access(3'b010, 12'h900, 32'h00000010, 5'd4, 5'd9, 5, o);
    e = sb_q.pop_front();
    n_chk++; if (o.stable !== 1'b1 || o.resp_cyc != 3) begin n_fail++;
      $display("FAIL stall_stable: got stable %b resp_cyc %0d expected 1/3", o.stable, o.resp_cyc); end
    n_chk++; if (o.rr_low !== 1'b1) begin n_fail++;
      $display("FAIL stall_req_ready: got ready-low %b expected 1", o.rr_low); end
    n_chk++; if (o.wdata !== e.wdata || {o.rdata, o.rd} !== {e.rdata, e.rd}) begin n_fail++;
      $display("FAIL stall_data: got %h/%h/%0d expected %h/%h/%0d", o.wdata, o.rdata, o.rd, e.wdata, e.rdata, e.rd); end
    run_access(3'b001, 12'h900, 32'h00000000, 5'd2, 5'd10, 0, o);
    e = sb_q.pop_front();
    n_chk++; if (o.acc_ready !== 1'b1 || o.resp_cyc != 3) begin n_fail++;
      $display("FAIL b2b_accept: got ready %b resp_cyc %0d expected 1/3", o.acc_ready, o.resp_cyc); end
    n_chk++; if (o.we_cnt != e.we_cnt || o.wdata !== e.wdata || {o.rdata, o.rd} !== {e.rdata, e.rd}) begin n_fail++;
      $display("FAIL b2b_data: got %0d/%h/%h/%0d expected %0d/%h/%h/%0d",
               o.we_cnt, o.wdata, o.rdata, o.rd, e.we_cnt, e.wdata, e.rdata, e.rd); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
    test_reset();
    test_rw();
    test_rs();
    test_imm();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global bound so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
